// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with input synchroniser and first-word-fall-through
// receive FIFO, level interrupt and sticky frame/overrun error flags.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rx,
    output logic [7:0]                        rd_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              irq,
    output logic                              frame_err,
    output logic                              overrun,
    input  logic                              err_clr
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Receiver state
    logic          sync1_q, sync2_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    // Frame-level events
    logic          push;
    logic          ferr_set;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          ovr_set;

    assign rx_s = sync2_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage needs no reset: rd_data is masked while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: stop-bit verdict
    always_comb begin
        push     = 1'b0;
        ferr_set = 1'b0;
        if (state_q == STOP && cnt_q == BIT_LAST) begin
            push     = rx_s;
            ferr_set = !rx_s;
        end
    end

    // FIFO control; a pop frees the slot a same-cycle push needs
    always_comb begin
        pop      = (count_q != '0) && rd_ready;
        full     = (count_q == FULL_CNT);
        wr_en    = push && (!full || pop);
        ovr_set  = push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Sticky flags: a set event beats a same-cycle clear
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (ferr_set) begin
            frame_err_d = 1'b1;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign irq        = rd_valid;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at default parameters.
// Frames are driven on falling clock edges; outputs are sampled there too.
module tb_uart_rx_fifo;

    localparam int C = 50000000 / 115200;
    // Stop-bit sample edge counted from the start-bit drive: 2 sync + half + 9 bits
    localparam int PUSH_OFS = 2 + C / 2 + 9 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       irq;
    logic       frame_err;
    logic       overrun;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .irq        (irq),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (C) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (C) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic pop_one(input logic [7:0] exp, input string name);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL %s: valid=%0b data=%02h required valid=1 data=%02h",
                     name, rd_valid, rd_data, exp);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_valid, irq, frame_err, overrun} !== 4'b0000 ||
            fifo_count !== 4'd0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: v=%0b irq=%0b fe=%0b ov=%0b cnt=%0d data=%02h required all 0",
                     rd_valid, irq, frame_err, overrun, fifo_count, rd_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_frame();
        send_frame(8'h41, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h41 || fifo_count !== 4'd1 ||
            irq !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rx_41: v=%0b data=%02h cnt=%0d irq=%0b fe=%0b required 1 41 1 1 0",
                     rd_valid, rd_data, fifo_count, irq, frame_err);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL pop_41: v=%0b cnt=%0d irq=%0b required 0 0 0",
                     rd_valid, fifo_count, irq);
        end
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (C) @(negedge clk);
        checks++;
        if (fifo_count !== 4'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL glitch: cnt=%0d fe=%0b ov=%0b required 0 0 0",
                     fifo_count, frame_err, overrun);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        repeat (C) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL frame_err_set: fe=%0b cnt=%0d required fe=1 cnt=0",
                     frame_err, fifo_count);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clr: fe=%0b required 0", frame_err);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        checks++;
        if (fifo_count !== 4'd8 || overrun !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL overrun: cnt=%0d ov=%0b head=%02h required 8 1 00",
                     fifo_count, overrun, rd_data);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL overrun_clr: ov=%0b cnt=%0d required 0 8",
                     overrun, fifo_count);
        end
    endtask

    task automatic test_full_push_pop();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (PUSH_OFS) @(negedge clk);
                pop_one(8'h00, "pop_on_push");
            end
        join
        repeat (2) @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL full_push_pop: ov=%0b cnt=%0d required 0 8",
                     overrun, fifo_count);
        end
        for (int i = 1; i < 8; i++) begin
            pop_one(8'(i), "drain_seq");
        end
        pop_one(8'hA5, "drain_last");
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty: v=%0b cnt=%0d required 0 0",
                     rd_valid, fifo_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h3C;
        uart_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = b[i];
            repeat (C) @(negedge clk);
        end
        rst = 1'b1;
        uart_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        send_frame(8'hC3, 1'b1);
        repeat (C) @(negedge clk);
        checks++;
        if (fifo_count !== 4'd1 || rd_data !== 8'hC3 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: cnt=%0d data=%02h fe=%0b required 1 C3 0",
                     fifo_count, rd_data, frame_err);
        end
        pop_one(8'hC3, "pop_c3");
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL after_c3: cnt=%0d required 0", fifo_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front end of the SoC: oversamples the asynchronous `uart_rx` pin and deserialises 8N1 frames.
- Received bytes are buffered in a small first-word-fall-through FIFO, read by the core's UART peripheral register interface via valid/ready.
- Raises a level interrupt to the core while data is pending.
- Sits directly downstream of the board-level `uart_rx` pin and upstream of the CPU bus slave.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults), must be >= 4.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idle high.
- rd_data  out  8  FIFO head byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer pops head on a cycle with rd_valid && rd_ready.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- irq  out  1  equals rd_valid (level).
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; byte dropped because FIFO was full.
- err_clr  in  1  clears frame_err and overrun.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, counters 0, FIFO empty. rd_valid=0, fifo_count=0, irq=0, frame_err=0, overrun=0, rd_data=0x00.
- Input sync: uart_rx passes through a 2-flop synchroniser, giving rx_s. Sync flops reset to 1. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP. A single clock counter `cnt` and a 3-bit `bit_idx`.
- IDLE: on rx_s==0, go to START with cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1, sample rx_s (mid start bit).
  - If 0: go to DATA with cnt=0, bit_idx=0.
  - If 1: glitch; return to IDLE, nothing recorded.
  - Otherwise cnt++.
- DATA: at cnt==CLKS_PER_BIT-1, shift[bit_idx]=rx_s (LSB first) and cnt=0.
  - When bit_idx==7, go to STOP; else bit_idx++.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s and go to IDLE.
  - rx_s==1: push the byte.
  - rx_s==0: set frame_err, discard the byte.
- Latency: a pushed byte appears on rd_data/rd_valid the cycle after the stop-sample cycle.
- FIFO: first-word fall-through; rd_data always shows the head.
  - Pop when rd_valid && rd_ready.
  - Push while empty: rd_valid rises next cycle. Pointers wrap modulo FIFO_DEPTH.
- Push while full:
  - With a pop in the same cycle: push accepted, count stays FIFO_DEPTH.
  - Without a pop: byte dropped, overrun set, FIFO contents unchanged.
- Simultaneous push and pop when not full: count unchanged.
- Pop when empty: ignored.
- Sticky flags: err_clr clears them next cycle. If a set event and err_clr occur in the same cycle, set wins.
- Break / line stuck low: the frame fails on its stop bit (frame_err). The FSM then re-enters IDLE and immediately sees rx_s==0, so it restarts frames. No deadlock; each failed frame re-asserts frame_err.
- Reset mid-frame: the partial byte is discarded, FIFO emptied, flags cleared. Reception resumes at the next falling edge after reset deasserts.

Test Plan:
- Frame 0x41 at defaults (bit time 434 clocks), rd_ready=0 → rd_valid=1, rd_data=0x41, fifo_count=1, irq=1, frame_err=0. Then pulse rd_ready for 1 cycle → fifo_count=0, rd_valid=0, irq=0.
- uart_rx low for 100 clocks, then high → FSM returns to IDLE; fifo_count stays 0, no flags.
- Frame 0x55 with the stop bit driven low → frame_err=1, fifo_count=0. Pulse err_clr → frame_err=0 next cycle.
- Frames 0x00..0x08 (9 bytes), rd_ready=0, FIFO_DEPTH=8 → fifo_count=8, overrun=1. Pop sequence yields 0x00..0x07; 0x08 is absent.
- FIFO full; hold rd_ready=1 on the cycle the 9th byte (0xA5) is pushed → overrun=0, fifo_count=8. Last entry popped is 0xA5.
- Assert rst for 1 cycle mid-DATA of frame 0x3C, then send a full frame 0xC3 → exactly one byte, 0xC3, received; no frame_err.
